// File: rtl/serializer_pkg.sv
// serializer_pkg
//   Shared definitions for the bit serializer and its matching receiver:
//   the frame FSM state encoding and a helper giving the length of one
//   frame in clock cycles.
package serializer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } ser_state_e;

    // Cycles in one frame: start + data + optional parity + stop bits,
    // each held for clks_per_bit cycles.
    function automatic int frame_len(input int width, input int clks_per_bit,
                                     input int parity_en);
        return (width + 2 + ((parity_en != 0) ? 1 : 0)) * clks_per_bit;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// bit_timer
//   Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and wraps;
//   held at 0 while disabled so every bit period starts from a clean count.
// Ports:
//   c      - clock, rising edge
//   rstn   - synchronous active-low reset
//   en     - count enable
//   wrap   - high in the last cycle of a bit period (en && cnt at max)
//   cnt    - current count
module bit_timer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic          c,
    input  logic          rstn,
    input  logic          en,
    output logic          wrap,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        wrap  = en && (cnt_q == CNT_MAX);
        cnt_d = '0;
        if (en && !wrap) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge c) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial transmitter. Accepts a WIDTH-bit word when idle and
//   sends: start bit (0), data LSB first, optional even parity, stop bit (1),
//   each bit lasting CLKS_PER_BIT cycles. All outputs come from flops.
// Ports:
//   c          - clock, rising edge
//   rstn       - synchronous active-low reset
//   din        - parallel word to send
//   din_valid  - din holds a word
//   din_ready  - block accepts a word this cycle (idle only)
//   sout       - serial line, 1 when idle
//   busy       - frame in progress
//   done       - one-cycle pulse in the final cycle of the stop bit
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic             c,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
    // done is registered, so it is raised one cycle before the last stop cycle
    localparam logic [CW-1:0] DONE_CNT = (CLKS_PER_BIT > 1) ? CW'(CLKS_PER_BIT - 2) : '0;

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             par_q, par_d;
    logic             sout_q, sout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             din_ready_q, din_ready_d;

    logic          wrap;
    logic [CW-1:0] cnt;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CW           (CW)
    ) u_bit_timer (
        .c    (c),
        .rstn (rstn),
        .en   (state_q != IDLE),
        .wrap (wrap),
        .cnt  (cnt)
    );

    // sout is computed for the state being entered so it changes on the
    // same edge as the state, giving a one-cycle start-bit latency.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        par_d   = par_q;
        sout_d  = sout_q;

        unique case (state_q)
            IDLE: begin
                sout_d = 1'b1;
                if (din_valid && din_ready_q) begin
                    state_d = START;
                    shreg_d = din;
                    par_d   = ^din;
                    idx_d   = '0;
                    sout_d  = 1'b0;
                end
            end
            START: begin
                if (wrap) begin
                    state_d = DATA;
                    sout_d  = shreg_q[0];
                end
            end
            DATA: begin
                if (wrap) begin
                    if (idx_q == IDX_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            sout_d  = par_q;
                        end else begin
                            state_d = STOP;
                            sout_d  = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        shreg_d = shreg_q >> 1;
                        sout_d  = shreg_d[0];
                    end
                end
            end
            PARITY: begin
                if (wrap) begin
                    state_d = STOP;
                    sout_d  = 1'b1;
                end
            end
            STOP: begin
                if (wrap) begin
                    state_d = IDLE;
                    sout_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sout_d  = 1'b1;
            end
        endcase

        busy_d      = (state_d != IDLE);
        din_ready_d = (state_d == IDLE);
        if (CLKS_PER_BIT == 1) begin
            done_d = (state_d == STOP);
        end else begin
            done_d = (state_q == STOP) && (cnt == DONE_CNT);
        end
    end

    always_ff @(posedge c) begin
        if (!rstn) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            idx_q       <= '0;
            par_q       <= 1'b0;
            sout_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            din_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            par_q       <= par_d;
            sout_q      <= sout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            din_ready_q <= din_ready_d;
        end
    end

    assign sout      = sout_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign din_ready = din_ready_q;

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer
//   Directed bench for bit_serializer. Three instances cover the parameter
//   corners: u0 (8,4,parity), u1 (8,1,parity), u2 (8,4,no parity).
module tb_bit_serializer;

    logic            c;
    logic            rstn;
    logic [2:0][7:0] din;
    logic [2:0]      vld;
    wire  [2:0]      rdy;
    wire  [2:0]      sout;
    wire  [2:0]      busy;
    wire  [2:0]      done;

    int checks = 0;
    int errors = 0;

    initial c = 1'b0;
    always #5 c = ~c;

    bit_serializer #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u0 (
        .c(c), .rstn(rstn), .din(din[0]), .din_valid(vld[0]),
        .din_ready(rdy[0]), .sout(sout[0]), .busy(busy[0]), .done(done[0]));
    bit_serializer #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) u1 (
        .c(c), .rstn(rstn), .din(din[1]), .din_valid(vld[1]),
        .din_ready(rdy[1]), .sout(sout[1]), .busy(busy[1]), .done(done[1]));
    bit_serializer #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u2 (
        .c(c), .rstn(rstn), .din(din[2]), .din_valid(vld[2]),
        .din_ready(rdy[2]), .sout(sout[2]), .busy(busy[2]), .done(done[2]));

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Send word w on instance sel and check every cycle of the frame.
    // smode 0: wait for ready and raise valid; 1: valid already up, transfer at next edge.
    // pmode 0: drop valid after transfer; 1: keep valid, switch din to nxt;
    //       2: drop valid, then toggle din/valid randomly during the frame.
    task automatic frame(input int sel, input logic [7:0] w, input int cpb, input int par,
                         input int smode, input int pmode, input logic [7:0] nxt,
                         input string tag);
        logic [10:0] bits;
        int n, nb, t;
        nb = 10 + par;
        n  = nb * cpb;
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = w[i];
        if (par != 0) bits[9] = ^w;
        bits[nb-1] = 1'b1;
        if (smode == 0) begin
            t = 0;
            while (!rdy[sel] && t < 50) begin
                @(negedge c);
                t++;
            end
            chk({tag, "_ready_before"}, rdy[sel], 1'b1);
            din[sel] = w;
            vld[sel] = 1'b1;
        end
        @(posedge c);
        #1;
        case (pmode)
            1:       din[sel] = nxt;
            default: vld[sel] = 1'b0;
        endcase
        for (int k = 1; k <= n; k++) begin
            @(negedge c);
            chk({tag, "_sout"}, sout[sel], bits[(k-1)/cpb]);
            chk({tag, "_busy"}, busy[sel], 1'b1);
            chk({tag, "_done"}, done[sel], (k == n));
            chk({tag, "_ready_busy"}, rdy[sel], 1'b0);
            if (pmode == 2) begin
                din[sel] = 8'($urandom);
                vld[sel] = 1'($urandom_range(0, 1));
            end
        end
        if (pmode == 2) vld[sel] = 1'b0;
        @(negedge c);
        chk({tag, "_idle_sout"}, sout[sel], 1'b1);
        chk({tag, "_idle_busy"}, busy[sel], 1'b0);
        chk({tag, "_idle_done"}, done[sel], 1'b0);
        chk({tag, "_idle_ready"}, rdy[sel], 1'b1);
    endtask

    initial begin
        logic saw_done;
        rstn = 1'b0;
        vld  = '0;
        din  = '0;

        // Reset state
        repeat (2) @(posedge c);
        @(negedge c);
        for (int s = 0; s < 3; s++) begin
            chk("rst_sout", sout[s], 1'b1);
            chk("rst_busy", busy[s], 1'b0);
            chk("rst_done", done[s], 1'b0);
            chk("rst_ready", rdy[s], 1'b0);
        end
        rstn = 1'b1;
        @(posedge c);
        @(negedge c);
        for (int s = 0; s < 3; s++) chk("ready_after_rst", rdy[s], 1'b1);

        // 0xA5, 4 clocks/bit, parity 0, done at cycle 44
        frame(0, 8'hA5, 4, 1, 0, 0, 8'h00, "a5");
        // 0x07, 1 clock/bit, parity 1, 11 cycles
        frame(1, 8'h07, 1, 1, 0, 0, 8'h00, "x07_cpb1");
        // 0x00, no parity, 10 bits
        frame(2, 8'h00, 4, 0, 0, 0, 8'h00, "x00_nopar");
        // Back-to-back with valid held: one idle cycle between frames
        frame(0, 8'h3C, 4, 1, 0, 1, 8'hC3, "b2b_3c");
        frame(0, 8'hC3, 4, 1, 1, 0, 8'h00, "b2b_c3");
        // Input activity during a frame is ignored
        frame(0, 8'h96, 4, 1, 0, 2, 8'h00, "toggle_96");
        frame(2, 8'hFF, 4, 0, 0, 2, 8'h00, "toggle_ff");
        frame(1, 8'h80, 1, 1, 0, 2, 8'h00, "toggle_80");

        // Reset during DATA bit 3 (cycles 17..20 after transfer)
        din[0] = 8'h5A;
        vld[0] = 1'b1;
        @(posedge c);
        #1 vld[0] = 1'b0;
        repeat (17) @(negedge c);
        chk("mid_bit3_sout", sout[0], 1'b1);
        chk("mid_busy", busy[0], 1'b1);
        rstn = 1'b0;
        @(posedge c);
        #1 rstn = 1'b1;
        @(negedge c);
        chk("abort_sout", sout[0], 1'b1);
        chk("abort_busy", busy[0], 1'b0);
        chk("abort_done", done[0], 1'b0);
        chk("abort_ready", rdy[0], 1'b0);
        saw_done = 1'b0;
        @(negedge c);
        chk("abort_ready_rise", rdy[0], 1'b1);
        for (int k = 0; k < 40; k++) begin
            if (done[0] || busy[0] || !sout[0]) saw_done = 1'b1;
            @(negedge c);
        end
        chk("abort_no_activity", saw_done, 1'b0);
        frame(0, 8'h5A, 4, 1, 0, 0, 8'h00, "after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; the clock port SHALL be named c and the reset port rstn.
REQ-002 Parameter WIDTH, default 8, SHALL set the data bits per frame (legal range 1..32).
REQ-003 Parameter CLKS_PER_BIT, default 4, SHALL set the c cycles per serial bit (legal range 1..256).
REQ-004 Parameter PARITY_EN, default 1, SHALL insert an even-parity bit when 1 and omit it when 0.
REQ-005 Port c, input, 1 bit, SHALL be the clock; all state SHALL update on its rising edge.
REQ-006 Port rstn, input, 1 bit, SHALL be the synchronous reset; 0 sampled at a rising edge of c resets the block.
REQ-007 Port din, input, WIDTH bits, SHALL carry the parallel word to transmit.
REQ-008 Port din_valid, input, 1 bit, SHALL indicate that din holds a word.
REQ-009 Port din_ready, output, 1 bit, SHALL indicate that the block accepts a word this cycle.
REQ-010 Port sout, output, 1 bit, SHALL be the registered serial line, which is 1 when idle.
REQ-011 Port busy, output, 1 bit, SHALL be 1 while a frame is in progress.
REQ-012 Port done, output, 1 bit, SHALL be a one-cycle pulse at frame completion.

Function
REQ-013 The frame SHALL be: start bit (0), WIDTH data bits LSB first, parity bit if PARITY_EN, then stop bit (1); each bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP with transitions IDLE->START on accept, START->DATA, DATA->PARITY or STOP after bit WIDTH-1, PARITY->STOP, and STOP->IDLE.
REQ-015 din_ready SHALL be 1 only in IDLE; a transfer SHALL occur at the edge where din_valid and din_ready are both 1.
REQ-016 din SHALL be captured into an internal shift register at the transfer edge; later changes to din SHALL NOT affect the frame.
REQ-017 sout SHALL drive the start bit (0) from the cycle after the transfer edge (latency 1 cycle).
REQ-018 busy SHALL be 1 from the cycle after the transfer through the last STOP cycle, and 0 in IDLE.
REQ-019 The parity bit SHALL equal the XOR of the WIDTH captured data bits.
REQ-020 done SHALL be 1 only during the final cycle of the stop bit.
REQ-021 After STOP the block SHALL spend at least one cycle in IDLE, so back-to-back frames are separated by exactly one idle (sout=1) cycle when din_valid is held at 1.
REQ-022 A total frame SHALL last (WIDTH+2+PARITY_EN)*CLKS_PER_BIT cycles.
REQ-023 din_valid SHALL be ignored while busy; no word is queued.
REQ-024 The bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap; the data-bit index SHALL count 0..WIDTH-1, with width ceil(log2) and a minimum of 1 bit.

Reset
REQ-025 While rstn=0 at a rising edge, the block SHALL enter IDLE with sout=1, busy=0, done=0, din_ready=0, and counters at 0.
REQ-026 din_ready SHALL rise in the first cycle after rstn is sampled 1.
REQ-027 A reset mid-frame SHALL abort the frame without any done pulse, and sout SHALL return to 1 at that edge.

Structure
REQ-028 The FSM state encodings and a frame-length constant function SHALL reside in a shared package/include, serializer_pkg, for reuse by the matching receiver.
REQ-029 The bit-period counter SHALL be a sub-module, bit_timer, with an enable input and a wrap-pulse output.
REQ-030 sout, busy, and done SHALL be driven directly from flops, with no combinational path from din or din_valid to sout.

Verification
REQ-031 With WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=1, and din=0xA5 with one din_valid pulse, sout SHALL show 0,1,0,1,0,0,1,0,1,0(parity),1 with each bit held 4 cycles, and done SHALL pulse at cycle 44 after the transfer.
REQ-032 With CLKS_PER_BIT=1 and din=0x07, the parity bit SHALL be 1 and the frame SHALL be 11 cycles long.
REQ-033 With PARITY_EN=0 and din=0x00, sout SHALL show a start bit, 8 zero bits, and a stop bit, giving 10*CLKS_PER_BIT cycles with no parity bit.
REQ-034 With din_valid held 1 and words 0x3C then 0xC3, there SHALL be two frames separated by exactly one idle cycle, each carrying the correct word.
REQ-035 With rstn=0 for one edge during DATA bit 3, sout SHALL be 1 and busy 0 at the next cycle, no done pulse SHALL occur, and the next accepted word SHALL be sent intact.
REQ-036 Toggling din_valid and din during a frame SHALL leave sout unchanged from the captured word, and din_ready SHALL stay 0 throughout.
